button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles a new level must persist before it is accepted (range 1..65535).
REQ-002 SHALL have parameter REPEAT_DELAY, default 16: cycles from first pulse to first auto-repeat pulse (range 2..65535).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 8: cycles between subsequent auto-repeat pulses (range 2..65535).
REQ-004 SHALL have port CLK  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port INC_BTN  input  1  raw +1 button, active-high, asynchronous to CLK.
REQ-007 SHALL have port INC10_BTN  input  1  raw +10 button, active-high, asynchronous.
REQ-008 SHALL have port CLR_BTN  input  1  raw clear button, active-high, asynchronous.
REQ-009 SHALL have port INC_P  output  1  one-cycle +1 command pulse to the scoreboard controller.
REQ-010 SHALL have port INC10_P  output  1  one-cycle +10 command pulse.
REQ-011 SHALL have port CLR_P  output  1  one-cycle clear-press pulse (controller counts these).
REQ-012 SHALL have port DB_LEVEL  output  3  debounced levels {CLR, INC10, INC}, status only.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer; only the second flop feeds later logic.
REQ-014 SHALL debounce per button: 16-bit counter increments each cycle synchronized level != debounced level, clears when equal; on reaching DEBOUNCE_CYCLES the debounced level toggles and counter clears.
REQ-015 SHALL give fixed latency: raw high first sampled at edge 1, held -> debounced high after edge DEBOUNCE_CYCLES+2, candidate pulse registered high after edge DEBOUNCE_CYCLES+3, for exactly one cycle.
REQ-016 SHALL ignore glitches: synchronized deviations shorter than DEBOUNCE_CYCLES produce no debounced change and no pulse.
REQ-017 SHALL run a per-button FSM for INC and INC10: IDLE -> (debounced rise) FIRST -> WAIT -> REPEAT -> REPEAT ...; any state -> IDLE on debounced fall.
REQ-018 SHALL emit a candidate pulse on FIRST entry, on WAIT->REPEAT after REPEAT_DELAY cycles from the FIRST pulse, then every REPEAT_PERIOD cycles while held.
REQ-019 SHALL NOT auto-repeat CLR: one candidate pulse per debounced rise only.
REQ-020 SHALL use 16-bit repeat timers that restart from 0 on every FSM entry to IDLE or FIRST; no wrap-around occurs within legal parameter ranges.
REQ-021 SHALL arbitrate candidates in the same cycle: CLR candidate forces INC_P and INC10_P to 0; INC and INC10 candidates together (no CLR) both drop to 0.
REQ-022 SHALL discard suppressed pulses (no deferral); FSM and timer progression unaffected by suppression.
REQ-023 SHALL register INC_P, INC10_P, CLR_P; no output is ever high two consecutive cycles.
REQ-024 SHALL drive DB_LEVEL directly from the debounced level registers.

Reset
REQ-025 SHALL, while RST high, asynchronously clear synchronizers, debounced levels, counters, timers, FSMs (IDLE) and all outputs to 0.
REQ-026 SHALL treat a button held across RST deassertion as a fresh press: pulse after edge DEBOUNCE_CYCLES+3 counted from first edge after release.
REQ-027 SHALL abort any in-progress debounce or repeat sequence on RST mid-operation, with no pulse emitted during or because of reset.

Verification
REQ-028 SHALL verify: defaults, INC_BTN high from before edge 1, held 10 cycles -> INC_P high only after edge 7, DB_LEVEL[0]=1 after edge 6.
REQ-029 SHALL verify: INC_BTN high 3 cycles then low -> INC_P never asserts, DB_LEVEL stays 000.
REQ-030 SHALL verify: INC10_BTN held 50 cycles -> INC10_P pulses after edges 7, 23, 31, 39, 47; none after release.
REQ-031 SHALL verify: CLR_BTN and INC_BTN rise same cycle, held 40 cycles -> CLR_P once after edge 7, INC_P suppressed at edge 7, INC_P pulses at 23, 31, 39.
REQ-032 SHALL verify: CLR_BTN pressed five separate times (20 high/20 low) -> exactly five CLR_P pulses.
REQ-033 SHALL verify: INC_BTN held, RST pulsed at edge 12 for 2 cycles -> all outputs 0 immediately, next INC_P 7 edges after RST release.

Source files
------------

// File: rtl/button_conditioner.sv
// Button conditioner for a scoreboard controller.
//
// Each of three raw, asynchronous, active-high buttons goes through a 2-flop
// synchronizer and a per-button debouncer. The +1 and +10 buttons then drive
// an auto-repeat FSM (first pulse, delay, periodic repeat while held); the
// clear button yields exactly one pulse per debounced press. Same-cycle
// candidates are arbitrated before the registered outputs.
//
// Ports:
//   CLK        input   clock, all state on the rising edge
//   RST        input   asynchronous active-high reset
//   INC_BTN    input   raw +1 button
//   INC10_BTN  input   raw +10 button
//   CLR_BTN    input   raw clear button
//   INC_P      output  one-cycle +1 command pulse
//   INC10_P    output  one-cycle +10 command pulse
//   CLR_P      output  one-cycle clear-press pulse
//   DB_LEVEL   output  debounced levels {CLR, INC10, INC}
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INC_BTN,
  input  logic       INC10_BTN,
  input  logic       CLR_BTN,
  output logic       INC_P,
  output logic       INC10_P,
  output logic       CLR_P,
  output logic [2:0] DB_LEVEL
);

  // Counters compare against N-1 so the event lands on the N-th counted cycle.
  localparam logic [15:0] DbLast     = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] DelayLast  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PeriodLast = 16'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StWait,
    StRepeat
  } rpt_state_e;

  logic [2:0]  raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  db_q;
  logic [15:0] db_cnt_q [3];

  assign raw      = {CLR_BTN, INC10_BTN, INC_BTN};
  assign DB_LEVEL = db_q;

  // Synchronizers and debouncers. The counter only runs while the synchronized
  // level disagrees with the accepted level, so any shorter glitch is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= ~db_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Auto-repeat FSMs: index 0 is INC, index 1 is INC10.
  rpt_state_e  state_q [2];
  rpt_state_e  state_d [2];
  logic [15:0] timer_q [2];
  logic [15:0] timer_d [2];
  logic [1:0]  rpt_cand;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      timer_d[i]  = timer_q[i] + 16'd1;
      rpt_cand[i] = 1'b0;
      if (!db_q[i]) begin
        state_d[i] = StIdle;
        timer_d[i] = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            state_d[i]  = StFirst;
            timer_d[i]  = '0;
            rpt_cand[i] = 1'b1;
          end
          StFirst: begin
            state_d[i] = StWait;
          end
          StWait: begin
            if (timer_q[i] == DelayLast) begin
              state_d[i]  = StRepeat;
              timer_d[i]  = '0;
              rpt_cand[i] = 1'b1;
            end
          end
          StRepeat: begin
            // Restarting on each repeat keeps the timer bounded while held.
            if (timer_q[i] == PeriodLast) begin
              timer_d[i]  = '0;
              rpt_cand[i] = 1'b1;
            end
          end
          default: begin
            state_d[i] = StIdle;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StIdle;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Clear: one candidate per debounced rise, never repeated.
  logic clr_seen_q;
  logic clr_cand;
  logic inc_p_d, inc10_p_d;

  assign clr_cand = db_q[2] & ~clr_seen_q;

  // Clear wins over both increments; simultaneous +1/+10 cancel each other.
  // Losers are discarded, the FSMs advance regardless.
  always_comb begin
    inc_p_d   = rpt_cand[0] & ~rpt_cand[1] & ~clr_cand;
    inc10_p_d = rpt_cand[1] & ~rpt_cand[0] & ~clr_cand;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clr_seen_q <= 1'b0;
      INC_P      <= 1'b0;
      INC10_P    <= 1'b0;
      CLR_P      <= 1'b0;
    end else begin
      clr_seen_q <= db_q[2];
      INC_P      <= inc_p_d;
      INC10_P    <= inc10_p_d;
      CLR_P      <= clr_cand;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters.
// Edge numbering: edge 1 is the first rising edge after buttons are applied;
// outputs are sampled 1 time unit after each rising edge.
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INC_BTN = 1'b0;
  logic       INC10_BTN = 1'b0;
  logic       CLR_BTN = 1'b0;
  logic       INC_P, INC10_P, CLR_P;
  logic [2:0] DB_LEVEL;

  int checks = 0;
  int fails  = 0;

  button_conditioner dut (
    .CLK       (CLK),
    .RST       (RST),
    .INC_BTN   (INC_BTN),
    .INC10_BTN (INC10_BTN),
    .CLR_BTN   (CLR_BTN),
    .INC_P     (INC_P),
    .INC10_P   (INC10_P),
    .CLR_P     (CLR_P),
    .DB_LEVEL  (DB_LEVEL)
  );

  always #5 CLK = ~CLK;

  // Holds reset for two cycles and releases it mid-cycle; the next rising
  // edge is edge 1.
  task automatic apply_reset();
    INC_BTN   = 1'b0;
    INC10_BTN = 1'b0;
    CLR_BTN   = 1'b0;
    RST       = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    INC_BTN   = 1'b1;
    INC10_BTN = 1'b1;
    CLR_BTN   = 1'b1;
    RST       = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    checks++;
    if ({INC_P, INC10_P, CLR_P, DB_LEVEL} !== 6'b0) begin
      fails++;
      $display("FAIL reset_hold: outputs=%b required 000000", {INC_P, INC10_P, CLR_P, DB_LEVEL});
    end
    apply_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({INC_P, INC10_P, CLR_P, DB_LEVEL} !== 6'b0) begin
      fails++;
      $display("FAIL reset_idle: outputs=%b required 000000", {INC_P, INC10_P, CLR_P, DB_LEVEL});
    end
  endtask

  task automatic test_latency();
    apply_reset();
    INC_BTN = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (INC_P !== (e == 7)) begin
        fails++;
        $display("FAIL latency_inc_p edge %0d: got %b required %b", e, INC_P, (e == 7));
      end
      checks++;
      if (DB_LEVEL !== ((e >= 6) ? 3'b001 : 3'b000)) begin
        fails++;
        $display("FAIL latency_db edge %0d: got %b required %b", e, DB_LEVEL,
                 ((e >= 6) ? 3'b001 : 3'b000));
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    INC_BTN = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK);
      #1;
      if (e == 3) INC_BTN = 1'b0;
      checks++;
      if (INC_P !== 1'b0 || DB_LEVEL !== 3'b000) begin
        fails++;
        $display("FAIL glitch edge %0d: INC_P=%b DB_LEVEL=%b required 0/000", e, INC_P, DB_LEVEL);
      end
    end
  endtask

  task automatic test_repeat();
    bit exp;
    apply_reset();
    INC10_BTN = 1'b1;
    for (int e = 1; e <= 90; e++) begin
      @(posedge CLK);
      #1;
      if (e == 50) INC10_BTN = 1'b0;
      exp = (e == 7 || e == 23 || e == 31 || e == 39 || e == 47);
      if (e <= 50 || e >= 56) begin
        checks++;
        if (INC10_P !== exp) begin
          fails++;
          $display("FAIL repeat_inc10_p edge %0d: got %b required %b", e, INC10_P, exp);
        end
      end
      checks++;
      if (INC_P !== 1'b0 || CLR_P !== 1'b0) begin
        fails++;
        $display("FAIL repeat_others edge %0d: INC_P=%b CLR_P=%b required 0", e, INC_P, CLR_P);
      end
      if (e == 55 || e == 56) begin
        checks++;
        if (DB_LEVEL !== ((e == 55) ? 3'b010 : 3'b000)) begin
          fails++;
          $display("FAIL repeat_db edge %0d: got %b required %b", e, DB_LEVEL,
                   ((e == 55) ? 3'b010 : 3'b000));
        end
      end
    end
  endtask

  task automatic test_arbitration();
    bit exp_inc;
    apply_reset();
    CLR_BTN = 1'b1;
    INC_BTN = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK);
      #1;
      exp_inc = (e == 23 || e == 31 || e == 39);
      checks++;
      if (CLR_P !== (e == 7)) begin
        fails++;
        $display("FAIL arb_clr_p edge %0d: got %b required %b", e, CLR_P, (e == 7));
      end
      checks++;
      if (INC_P !== exp_inc) begin
        fails++;
        $display("FAIL arb_inc_p edge %0d: got %b required %b", e, INC_P, exp_inc);
      end
      checks++;
      if (INC10_P !== 1'b0) begin
        fails++;
        $display("FAIL arb_inc10_p edge %0d: got %b required 0", e, INC10_P);
      end
    end
    CLR_BTN = 1'b0;
    INC_BTN = 1'b0;
    repeat (20) @(posedge CLK);
  endtask

  task automatic test_back_to_back();
    int  n_clr = 0;
    int  n_other = 0;
    int  n_consec = 0;
    logic prev = 1'b0;
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 40; c++) begin
        CLR_BTN = (c < 20);
        @(posedge CLK);
        #1;
        if (CLR_P === 1'b1) n_clr++;
        if (CLR_P === 1'b1 && prev === 1'b1) n_consec++;
        if (INC_P !== 1'b0 || INC10_P !== 1'b0) n_other++;
        prev = CLR_P;
      end
    end
    CLR_BTN = 1'b0;
    checks++;
    if (n_clr != 5) begin
      fails++;
      $display("FAIL b2b_clr_count: got %0d required 5", n_clr);
    end
    checks++;
    if (n_consec != 0 || n_other != 0) begin
      fails++;
      $display("FAIL b2b_clean: consecutive=%0d stray=%0d required 0/0", n_consec, n_other);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    INC_BTN = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    checks++;
    if ({INC_P, INC10_P, CLR_P, DB_LEVEL} !== 6'b0) begin
      fails++;
      $display("FAIL rst_mid_async: outputs=%b required 000000", {INC_P, INC10_P, CLR_P, DB_LEVEL});
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({INC_P, INC10_P, CLR_P, DB_LEVEL} !== 6'b0) begin
        fails++;
        $display("FAIL rst_mid_hold %0d: outputs=%b required 000000", k,
                 {INC_P, INC10_P, CLR_P, DB_LEVEL});
      end
    end
    RST = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (INC_P !== (k == 7)) begin
        fails++;
        $display("FAIL rst_mid_inc_p edge %0d: got %b required %b", k, INC_P, (k == 7));
      end
      checks++;
      if (DB_LEVEL[0] !== (k >= 6)) begin
        fails++;
        $display("FAIL rst_mid_db edge %0d: got %b required %b", k, DB_LEVEL[0], (k >= 6));
      end
    end
    INC_BTN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_repeat();
    test_arbitration();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
